// File: rtl/display_pkg.sv
// Shared constants and conversion FSM encoding for the display scan path.
package display_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam int          BCD_MAX    = 9999;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a valid/ready input
// and a one-cycle commit strobe that qualifies the finished BCD word.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int VALUE_W = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [VALUE_W-1:0]        val_in,
    input  logic                      val_valid,
    output logic                      val_ready,
    output logic                      ovf,
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic                      commit
);
    localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int BCD_W = 4 * NUM_DIGITS;

    conv_state_t        r_state;
    conv_state_t        w_state_next;
    logic [VALUE_W-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_ovf;

    logic               w_accept;
    logic               w_too_big;
    logic               w_last_shift;
    logic [VALUE_W-1:0] w_clamped;
    logic [BCD_W-1:0]   w_adj;

    assign w_accept     = (r_state == ST_IDLE) && val_valid;
    assign w_too_big    = 32'(val_in) > 32'(BCD_MAX);
    assign w_clamped    = w_too_big ? VALUE_W'(BCD_MAX) : val_in;
    assign w_last_shift = (r_bit_cnt == CNT_W'(VALUE_W - 1));

    // Add-3 correction on every nibble that would overflow past 9 when doubled
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                      r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_next = ST_SHIFT;
            ST_SHIFT:  if (w_last_shift) w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        val_ready = 1'b0;
        commit    = 1'b0;
        case (r_state)
            ST_IDLE:   val_ready = 1'b1;
            ST_COMMIT: commit    = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_bin     <= w_clamped;
                        r_bcd     <= '0;
                        r_bit_cnt <= '0;
                        r_ovf     <= w_too_big;
                    end
                end
                ST_SHIFT: begin
                    {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                    r_bit_cnt      <= r_bit_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bcd = r_bcd;
    assign ovf = r_ovf;

endmodule

// File: rtl/display_scan_mux.sv
// Binary value -> 4 BCD digits -> time-multiplexed digit code + active-low anode.
// Optional leading-zero blanking is enabled with `define LEADING_ZERO_BLANK_EN.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] val_in,
    input  logic               val_valid,
    output logic               val_ready,
    output logic               ovf,
    output logic [3:0]         data_out,
    output logic [3:0]         dig_out
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] w_bcd;
    logic                    w_commit;
    logic [3:0]              w_code [NUM_DIGITS];

    logic [CNT_W-1:0]        r_refresh_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [3:0]              r_disp [NUM_DIGITS];
    logic [3:0]              r_data_out;
    logic [3:0]              r_dig_out;
    logic                    w_wrap;

    bin2bcd_seq #(
        .VALUE_W (VALUE_W)
    ) u_bin2bcd (
        .clk       (clk),
        .rst_n     (rst_n),
        .val_in    (val_in),
        .val_valid (val_valid),
        .val_ready (val_ready),
        .ovf       (ovf),
        .bcd       (w_bcd),
        .commit    (w_commit)
    );

    // Per-digit code stored at commit time; blanking applies to every digit
    // above the most significant non-zero one, never to the units digit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_code
`ifdef LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_units
                assign w_code[gi] = w_bcd[3:0];
            end else begin : g_upper
                assign w_code[gi] = (w_bcd[4*NUM_DIGITS-1 : 4*gi] == '0) ?
                                    BLANK_CODE : w_bcd[4*gi +: 4];
            end
`else
            assign w_code[gi] = w_bcd[4*gi +: 4];
`endif
        end
    endgenerate

    assign w_wrap = (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_idx         <= '0;
            r_data_out    <= 4'h0;
            r_dig_out     <= 4'b1111;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_disp[i] <= 4'h0;
            end
        end else begin
            if (w_commit) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_disp[i] <= w_code[i];
                end
            end
            if (w_wrap) begin
                r_refresh_cnt <= '0;
                r_idx         <= r_idx + IDX_W'(1);
                r_dig_out     <= ~(4'b0001 << r_idx);
                // Bypass so a slot starting on the commit edge already shows the new value
                r_data_out    <= w_commit ? w_code[r_idx] : r_disp[r_idx];
            end else begin
                r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
            end
        end
    end

    assign data_out = r_data_out;
    assign dig_out  = r_dig_out;

endmodule

// File: tb/tb_display_scan_mux.sv
// Randomized and directed bench for display_scan_mux against a decimal-arithmetic
// reference model; honours `define LEADING_ZERO_BLANK_EN when set.
module tb_display_scan_mux;

    localparam int VALUE_W     = 14;
    localparam int REFRESH_DIV = 4;
    localparam int NDIG        = 4;

    logic               clk;
    logic               rst_n;
    logic [VALUE_W-1:0] val_in;
    logic               val_valid;
    logic               val_ready;
    logic               ovf;
    logic [3:0]         data_out;
    logic [3:0]         dig_out;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    // Reference model state
    int cyc;
    bit busy;
    int commit_cyc;
    int pend_val;
    int m_dig [NDIG];
    int m_ovf;
    int m_dig_out;
    int m_data;
    bit m_acc;
    int pow10 [NDIG] = '{1, 10, 100, 1000};

    display_scan_mux #(
        .VALUE_W     (VALUE_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .val_in    (val_in),
        .val_valid (val_valid),
        .val_ready (val_ready),
        .ovf       (ovf),
        .data_out  (data_out),
        .dig_out   (dig_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int digit_code(int v, int i);
        int d;
        d = (v / pow10[i]) % 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && v < pow10[i]) d = 15;
`endif
        return d;
    endfunction

    always @(posedge clk) begin
        m_acc = 0;
        if (!rst_n) begin
            if (busy) $display("reset: pending value %0d dropped", pend_val);
            cyc       = 0;
            busy      = 0;
            m_ovf     = 0;
            m_dig_out = 4'hF;
            m_data    = 0;
            for (int i = 0; i < NDIG; i++) m_dig[i] = 0;
        end else begin
            cyc++;
            if (busy && cyc == commit_cyc) begin
                for (int i = 0; i < NDIG; i++) m_dig[i] = digit_code(pend_val, i);
                busy = 0;
            end else if (!busy && val_valid) begin
                int v;
                v          = int'(val_in);
                m_ovf      = (v > 9999) ? 1 : 0;
                pend_val   = (v > 9999) ? 9999 : v;
                busy       = 1;
                commit_cyc = cyc + VALUE_W + 1;
                m_acc      = 1;
                $display("accept val=%0d shown=%0d ovf=%0d cycle=%0d", v, pend_val, m_ovf, cyc);
            end
            if (cyc % REFRESH_DIV == 0) begin
                int idx;
                idx       = ((cyc / REFRESH_DIV) - 1) % NDIG;
                m_dig_out = 4'hF ^ (1 << idx);
                m_data    = m_dig[idx];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("val_ready", 32'(val_ready), busy ? 32'd0 : 32'd1);
            check("ovf",       32'(ovf),       32'(m_ovf));
            check("dig_out",   32'(dig_out),   32'(m_dig_out));
            check("data_out",  32'(data_out),  32'(m_data));
        end
    end

    task automatic send(input int v);
        bit got;
        got       = 0;
        val_in    = VALUE_W'(v);
        val_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_acc) begin
                got = 1;
                break;
            end
        end
        val_valid = 1'b0;
        if (!got) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        val_in    = '0;
        val_valid = 1'b0;
        busy      = 0;
        cyc       = 0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        idle(2);
        rst_n = 1'b1;
        idle(3 * REFRESH_DIV);

        send(1234);   idle(VALUE_W + 6 * REFRESH_DIV);
        send(16383);  idle(VALUE_W + 5 * REFRESH_DIV);
        send(42);     idle(VALUE_W + 5 * REFRESH_DIV);
        send(7);      idle(VALUE_W + 5 * REFRESH_DIV);
        send(0);      idle(VALUE_W + 5 * REFRESH_DIV);
        send(5555);
        send(8888);   idle(VALUE_W + 5 * REFRESH_DIV);
        send(9999);   idle(5);
        rst_n = 1'b0; idle(1);
        rst_n = 1'b1; idle(6 * REFRESH_DIV);

        for (int c = 0; c < 4000; c++) begin
            val_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0)
                val_in = VALUE_W'($urandom_range(0, 120));
            else
                val_in = VALUE_W'($urandom_range(0, 16383));
            rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        val_valid = 1'b0;
        rst_n     = 1'b1;
        idle(VALUE_W + 5 * REFRESH_DIV);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
